// File: rtl/vdp_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_slot_pkg
// Description : Shared types and constants for the MSX slot I/O responder.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_slot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4,
    DONE    = 3'd5
  } slot_state_e;

  localparam logic [7:0] DEFAULT_IO_BASE = 8'h88;

  // Port offsets inside the 4-port window.
  localparam logic [1:0] PORT_VRAM     = 2'd0;
  localparam logic [1:0] PORT_CTRL     = 2'd1;
  localparam logic [1:0] PORT_PALETTE  = 2'd2;
  localparam logic [1:0] PORT_INDIRECT = 2'd3;

  // Bit positions of the strobes inside the synchroniser vector.
  localparam int SYNC_WIDTH = 3;
  localparam int SYNC_IORQ  = 2;
  localparam int SYNC_RD    = 1;
  localparam int SYNC_WR    = 0;

  function automatic logic io_window_hit(input logic [5:0] addr_hi,
                                         input logic [5:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msx_slot_sync.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_sync
// Description : N-stage multi-bit synchroniser, flops reset to all-ones so
//               active-low strobes read as inactive out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_slot_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sync_out = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/msx_slot_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_io_responder
// Description : Cartridge-side target for Z80 slot I/O cycles; converts each
//               decoded access into one valid/ready bus transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_slot_io_responder
  import vdp_slot_pkg::*;
#(
  parameter logic [7:0] IO_BASE     = DEFAULT_IO_BASE,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  input  logic       init_busy,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  logic [SYNC_WIDTH-1:0] strobe_raw;
  logic [SYNC_WIDTH-1:0] strobe_sync;
  logic                  iorq_s;
  logic                  rd_s;
  logic                  wr_s;
  logic                  addr_hit;
  logic                  wait_hold;

  slot_state_e state_q, state_d;
  logic        abort_q, abort_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_write_q, bus_write_d;
  logic [1:0]  bus_address_q, bus_address_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic [7:0]  slot_d_out_q, slot_d_out_d;
  logic        slot_data_dir_q, slot_data_dir_d;
  logic        slot_wait_q, slot_wait_d;

  assign strobe_raw = {slot_iorq_n, slot_rd_n, slot_wr_n};

  msx_slot_sync #(
    .WIDTH  (SYNC_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (strobe_raw),
    .sync_out (strobe_sync)
  );

  assign iorq_s   = strobe_sync[SYNC_IORQ];
  assign rd_s     = strobe_sync[SYNC_RD];
  assign wr_s     = strobe_sync[SYNC_WR];
  assign addr_hit = io_window_hit(slot_a[7:2], IO_BASE[7:2]);

  always_comb begin
    state_d         = state_q;
    abort_d         = abort_q;
    bus_valid_d     = bus_valid_q;
    bus_write_d     = bus_write_q;
    bus_address_d   = bus_address_q;
    bus_wdata_d     = bus_wdata_q;
    slot_d_out_d    = slot_d_out_q;
    slot_data_dir_d = slot_data_dir_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        // Address and data are sampled raw: they settled long before the
        // synchronised strobes reached this point.
        if (!iorq_s && (!wr_s || !rd_s)) begin
          if (addr_hit) begin
            bus_address_d = slot_a[1:0];
            bus_wdata_d   = slot_d_in;
            bus_valid_d   = 1'b1;
            bus_write_d   = !wr_s;
            state_d       = !wr_s ? WR_REQ : RD_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end

      WR_REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = DONE;
        end
      end

      RD_REQ: begin
        if (iorq_s) begin
          abort_d = 1'b1;
        end
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (iorq_s) begin
          abort_d = 1'b1;
        end
        if (bus_rdata_en) begin
          // An abandoned read still consumes its data strobe, then drops it.
          if (abort_q || iorq_s) begin
            state_d = IDLE;
          end else begin
            slot_d_out_d    = bus_rdata;
            slot_data_dir_d = !rd_s;
            state_d         = RD_HOLD;
          end
        end
      end

      RD_HOLD: begin
        if (rd_s || iorq_s) begin
          slot_data_dir_d = 1'b0;
          state_d         = DONE;
        end else begin
          slot_data_dir_d = 1'b1;
        end
      end

      DONE: begin
        slot_data_dir_d = 1'b0;
        if (iorq_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d         = IDLE;
        bus_valid_d     = 1'b0;
        slot_data_dir_d = 1'b0;
      end
    endcase
  end

  // Wait covers the span from detect until the write is accepted or the read
  // data is in hand; the slot cycle ending always releases it.
  assign wait_hold   = (state_d == WR_REQ) || (state_d == RD_REQ) ||
                       (state_d == RD_WAIT);
  assign slot_wait_d = init_busy || (!iorq_s && wait_hold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      abort_q         <= 1'b0;
      bus_valid_q     <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= 2'd0;
      bus_wdata_q     <= 8'd0;
      slot_d_out_q    <= 8'd0;
      slot_data_dir_q <= 1'b0;
      slot_wait_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      abort_q         <= abort_d;
      bus_valid_q     <= bus_valid_d;
      bus_write_q     <= bus_write_d;
      bus_address_q   <= bus_address_d;
      bus_wdata_q     <= bus_wdata_d;
      slot_d_out_q    <= slot_d_out_d;
      slot_data_dir_q <= slot_data_dir_d;
      slot_wait_q     <= slot_wait_d;
    end
  end

  assign slot_d_out    = slot_d_out_q;
  assign slot_data_dir = slot_data_dir_q;
  assign slot_wait     = slot_wait_q;
  assign bus_valid     = bus_valid_q;
  assign bus_write     = bus_write_q;
  assign bus_address   = bus_address_q;
  assign bus_wdata     = bus_wdata_q;

endmodule
`default_nettype wire
